matmul_scheduler: RTL and testbench

Sequencer that computes C = A × B for two N×N signed 8-bit matrices using one shared external multiplier instance. It latches both operand matrices, issues one multiply per cycle, accumulates dot products at extended width, and saturates each result to 8 bits. It reports completion and a sticky overflow flag. It sits between the coprocessor register/command layer, which supplies the matrices and `start`, and the signed multiplier, whose operand and product ports it drives and consumes.

---
 rtl/matmul_scheduler.sv | 91 +++++++++
 tb/tb_matmul_scheduler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/matmul_scheduler.sv
// matmul_scheduler: computes C = A x B for N x N signed matrices over one shared combinational multiplier.
// Dot products accumulate at AW bits and are saturated to W bits; ovf is sticky per operation.
module matmul_scheduler #(
  parameter int N = 5,
  parameter int W = 8,
  parameter int AW = W + 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [N*N*W-1:0] mat_a_i,
  input  logic [N*N*W-1:0] mat_b_i,
  output logic [W-1:0]     mul_a_o,
  output logic [W-1:0]     mul_b_o,
  input  logic [W-1:0]     mul_prod_i,
  input  logic             mul_ovf_i,
  output logic [N*N*W-1:0] mat_c_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             ovf_o
);
  localparam int IW = $clog2(N);
  localparam logic signed [AW-1:0] MAXV = AW'(2**(W-1)-1);
  localparam logic signed [AW-1:0] MINV = ~MAXV;
  typedef enum logic [2:0] {IDLE, LOAD, MAC, WRITE, DONE} state_e;
  state_e state_q;
  logic [N*N*W-1:0] a_q, b_q, c_q;
  logic [IW-1:0] i_q, j_q, k_q;
  logic signed [AW-1:0] acc_q, acc_d;
  logic eovf_q, ovf_q, acc_hi, acc_lo, last_k, last_j, last_i;
  logic [W-1:0] sat;
  assign acc_d   = acc_q + {{(AW-W){mul_prod_i[W-1]}}, mul_prod_i};
  assign acc_hi  = acc_q > MAXV;
  assign acc_lo  = acc_q < MINV;
  assign sat     = acc_hi ? {1'b0, {(W-1){1'b1}}} : acc_lo ? {1'b1, {(W-1){1'b0}}} : acc_q[W-1:0];
  assign last_k  = k_q == IW'(N-1);
  assign last_j  = j_q == IW'(N-1);
  assign last_i  = i_q == IW'(N-1);
  assign mul_a_o = (state_q == MAC) ? a_q[(int'(i_q)*N+int'(k_q))*W +: W] : '0;
  assign mul_b_o = (state_q == MAC) ? b_q[(int'(k_q)*N+int'(j_q))*W +: W] : '0;
  assign mat_c_o = c_q;
  assign ovf_o   = ovf_q;
  assign busy_o  = state_q == LOAD || state_q == MAC || state_q == WRITE;
  assign done_o  = state_q == DONE;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      eovf_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_i) state_q <= LOAD;
        LOAD: begin
          a_q     <= mat_a_i;
          b_q     <= mat_b_i;
          c_q     <= '0;
          i_q     <= '0;
          j_q     <= '0;
          k_q     <= '0;
          acc_q   <= '0;
          eovf_q  <= 1'b0;
          ovf_q   <= 1'b0;
          state_q <= MAC;
        end
        MAC: begin
          acc_q   <= acc_d;
          eovf_q  <= eovf_q | mul_ovf_i;
          k_q     <= last_k ? '0 : k_q + IW'(1);
          state_q <= last_k ? WRITE : MAC;
        end
        WRITE: begin
          c_q[(int'(i_q)*N+int'(j_q))*W +: W] <= sat;
          ovf_q   <= ovf_q | eovf_q | acc_hi | acc_lo;
          acc_q   <= '0;
          eovf_q  <= 1'b0;
          j_q     <= last_j ? '0 : j_q + IW'(1);
          if (last_j) i_q <= i_q + IW'(1);
          state_q <= (last_i && last_j) ? DONE : MAC;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_matmul_scheduler.sv
// tb_matmul_scheduler: random and directed operations checked every cycle against a cycle-position
// reference model of the schedule plus a plain-arithmetic matrix product model.
module tb_matmul_scheduler;
  localparam int N = 5;
  localparam int W = 8;
  localparam int M = N*N*W;
  localparam int LAST = 1 + N*N*(N+1);
  logic clk = 0, rst_n = 0, start = 0;
  logic [M-1:0] mat_a, mat_b, mat_c;
  logic [W-1:0] mul_a, mul_b, mul_prod;
  logic mul_ovf, busy, done, ovf;
  logic signed [15:0] full;
  int checks = 0, errors = 0;
  int ph = -1;
  logic [M-1:0] ma, mb, rc, hc = '0;
  logic rovf, hovf = 1'b0;
  int cyc;
  logic [M-1:0] ta, tb;

  matmul_scheduler dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mat_a_i(mat_a), .mat_b_i(mat_b),
    .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_prod_i(mul_prod), .mul_ovf_i(mul_ovf),
    .mat_c_o(mat_c), .busy_o(busy), .done_o(done), .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  // Wrapping multiplier that flags results outside the signed 8-bit range.
  assign full = $signed(mul_a) * $signed(mul_b);
  assign mul_prod = full[7:0];
  assign mul_ovf = full > 16'sd127 || full < -16'sd128;

  function automatic logic [M:0] model(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] c = '0;
    logic o = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int acc = 0;
        for (int k = 0; k < N; k++) begin
          int p = $signed(a[(i*N+k)*W +: W]) * $signed(b[(k*N+j)*W +: W]);
          if (p > 127 || p < -128) o = 1'b1;
          acc += int'(byte'(p));
        end
        if (acc > 127) begin acc = 127; o = 1'b1; end
        if (acc < -128) begin acc = -128; o = 1'b1; end
        c[(i*N+j)*W +: W] = 8'(acc);
      end
    return {o, c};
  endfunction

  function automatic logic [M-1:0] fill(input int v);
    logic [M-1:0] r;
    for (int e = 0; e < N*N; e++) r[e*W +: W] = 8'(v);
    return r;
  endfunction

  function automatic logic [M-1:0] rnd();
    logic [M-1:0] r;
    for (int e = 0; e < N*N; e++) r[e*W +: W] = 8'($urandom);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [M-1:0] act, input logic [M-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle position since the sampled start: 1 = LOAD, 2..LAST = MAC/WRITE, LAST+1 = DONE.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ph <= -1;
      hc <= '0;
      hovf <= 1'b0;
    end else if (ph == -1) begin
      if (start) ph <= 1;
    end else if (ph == 1) begin
      ph <= 2;
      ma <= mat_a;
      mb <= mat_b;
      {rovf, rc} <= model(mat_a, mat_b);
      hc <= '0;
      hovf <= 1'b0;
    end else if (ph == LAST) begin
      ph <= LAST + 1;
      hc <= rc;
      hovf <= rovf;
    end else begin
      ph <= (ph == LAST + 1) ? -1 : ph + 1;
    end

  always @(negedge clk) begin
    int e, k;
    logic [W-1:0] ea, eb;
    ea = '0;
    eb = '0;
    if (ph >= 2 && ph <= LAST && (ph-2) % (N+1) < N) begin
      e = (ph-2) / (N+1);
      k = (ph-2) % (N+1);
      ea = ma[((e/N)*N+k)*W +: W];
      eb = mb[(k*N+e%N)*W +: W];
    end
    chk("busy", M'(busy), M'(ph >= 1 && ph <= LAST));
    chk("done", M'(done), M'(ph == LAST + 1));
    chk("mul_a", M'(mul_a), M'(ea));
    chk("mul_b", M'(mul_b), M'(eb));
    if (ph <= 2 || ph == LAST + 1) begin
      chk("mat_c", mat_c, hc);
      chk("ovf", M'(ovf), M'(hovf));
    end
  end

  task automatic run_op(input logic [M-1:0] a, input logic [M-1:0] b, input int disturb,
                        input int rst_at, output int c_done);
    c_done = 0;
    @(negedge clk);
    mat_a = a;
    mat_b = b;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1 || c == disturb + 1) start = 1'b0;
      if (c == disturb) begin start = 1'b1; mat_a = rnd(); end
      if (c == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("async rst busy", M'(busy), '0);
        chk("async rst mat_c", mat_c, '0);
        chk("async rst mul_a", M'(mul_a), '0);
        chk("async rst ovf", M'(ovf), '0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (done) begin c_done = c; return; end
    end
    errors++;
    $display("FAIL timeout: done not seen within 200 cycles");
  endtask

  initial begin
    repeat (3) begin
      @(negedge clk);
      mat_a = rnd();
      mat_b = rnd();
      start = 1'($urandom_range(0, 1));
      chk("reset busy", M'(busy), '0);
      chk("reset done", M'(done), '0);
      chk("reset mat_c", mat_c, '0);
      chk("reset mul", M'({mul_a, mul_b, ovf}), '0);
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    ta = '0;
    for (int i = 0; i < N; i++) ta[(i*N+i)*W +: W] = 8'd1;
    for (int e = 0; e < N*N; e++) tb[e*W +: W] = 8'(e + 1);
    run_op(ta, tb, 0, 0, cyc);
    chk("identity latency", M'(cyc), M'(152));
    chk("identity C", mat_c, tb);
    chk("identity ovf", M'(ovf), '0);
    run_op(fill(-1), fill(2), 0, 0, cyc);
    chk("signed C", mat_c, fill(-10));
    chk("signed ovf", M'(ovf), '0);
    run_op(fill(10), fill(10), 0, 0, cyc);
    chk("sat pos C", mat_c, fill(127));
    chk("sat pos ovf", M'(ovf), M'(1));
    run_op(fill(10), fill(-10), 0, 0, cyc);
    chk("sat neg C", mat_c, fill(-128));
    chk("sat neg ovf", M'(ovf), M'(1));
    tb = fill(1);
    tb[W-1:0] = 8'd16;
    run_op(fill(16), tb, 0, 0, cyc);
    chk("movf c00", M'(mat_c[W-1:0]), M'(64));
    chk("movf c11", M'(mat_c[(N+1)*W +: W]), M'(80));
    chk("movf ovf", M'(ovf), M'(1));
    for (int e = 0; e < N*N; e++) tb[e*W +: W] = 8'(e + 1);
    run_op(ta, tb, 40, 0, cyc);
    chk("busy start latency", M'(cyc), M'(152));
    chk("busy start C", mat_c, tb);
    run_op(rnd(), rnd(), 0, 60, cyc);
    run_op(rnd(), rnd(), 0, 0, cyc);
    chk("after reset latency", M'(cyc), M'(152));
    repeat (4) begin
      run_op(rnd(), rnd(), 0, 0, cyc);
      chk("random latency", M'(cyc), M'(152));
    end
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
